// File: rtl/apb_master_arb.sv
// apb_master_arb: round-robin arbiter sharing one APB master port among NREQ requesters,
// with one SETUP/ACCESS transfer per grant and a bounded wait on pready.
module apb_master_arb #(
    parameter int NREQ    = 2,
    parameter int AW      = 16,
    parameter int DW      = 32,
    parameter int TIMEOUT = 64
) (
    input  logic               pclk,
    input  logic               presetn,
    input  logic [NREQ-1:0]    req_valid,
    output logic [NREQ-1:0]    req_ready,
    input  logic [NREQ-1:0]    req_write,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_wdata,
    output logic [NREQ-1:0]    rsp_valid,
    output logic [DW-1:0]      rsp_rdata,
    output logic               rsp_err,
    output logic [AW-1:0]      paddr,
    output logic [DW-1:0]      pwdata,
    output logic               pwrite,
    output logic               psel,
    output logic               penable,
    input  logic               pready,
    input  logic [DW-1:0]      prdata
);
    localparam int PW = $clog2(NREQ);
    localparam int CW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t        r_state, w_next;
    logic [PW-1:0] r_ptr, r_gnt, w_g, w_ptr_nxt;
    logic [CW-1:0] r_cnt;
    logic          w_any, w_take, w_to, w_done;

    // Scan downward so the lowest offset from the pointer wins.
    always_comb begin
        w_g = '0;
        for (int k = NREQ - 1; k >= 0; k--)
            if (req_valid[(int'(r_ptr) + k) % NREQ]) w_g = PW'((int'(r_ptr) + k) % NREQ);
    end

    assign w_any     = |req_valid;
    assign w_take    = r_state == IDLE && w_any;
    assign w_to      = TIMEOUT != 0 && int'(r_cnt) == TIMEOUT - 1;
    assign w_done    = r_state == ACCESS && (pready || w_to);
    assign w_ptr_nxt = int'(w_g) == NREQ - 1 ? '0 : w_g + 1'b1;

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) r_state <= IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = w_any ? SETUP : IDLE;
            SETUP:   w_next = ACCESS;
            ACCESS:  w_next = (pready || w_to) ? IDLE : ACCESS;
            default: w_next = IDLE;
        endcase
    end

    // req_ready is gated by presetn so it drops together with the async reset.
    always_comb begin
        psel      = r_state != IDLE;
        penable   = r_state == ACCESS;
        req_ready = (presetn && w_take) ? NREQ'(1) << w_g : '0;
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            r_ptr     <= '0;
            r_gnt     <= '0;
            r_cnt     <= '0;
            paddr     <= '0;
            pwdata    <= '0;
            pwrite    <= 1'b0;
            rsp_valid <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= '0;
            if (w_take) begin
                paddr  <= req_addr[int'(w_g)*AW +: AW];
                pwrite <= req_write[w_g];
                pwdata <= req_write[w_g] ? req_wdata[int'(w_g)*DW +: DW] : '0;
                r_gnt  <= w_g;
                r_ptr  <= w_ptr_nxt;
                r_cnt  <= '0;
            end
            if (r_state == ACCESS && !pready) r_cnt <= r_cnt + 1'b1;
            if (w_done) begin
                rsp_valid <= NREQ'(1) << r_gnt;
                rsp_err   <= !pready;
                rsp_rdata <= (pready && !pwrite) ? prdata : '0;
            end
        end
    end
endmodule
